// File: rtl/onchip_mem_s2_arbiter.sv
// Round-robin arbiter sharing the s2 port of the dual-port on-chip RAM between two
// Avalon-MM masters. It tracks the RAM's 1-cycle read latency and routes readdatavalid.
module onchip_mem_s2_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] read_vec;
  logic [1:0] write_vec;
  logic [1:0] req;
  logic [1:0] rd_only;
  logic [1:0] grant;
  logic [1:0] wait_vec;
  logic [1:0] rdv_vec;
  logic [1:0] rd_pend_reg;
  logic [1:0] rd_pend_next;
  logic       last_grant_reg;  // index of the most recently granted master
  logic       sel_m1;

  assign read_vec  = {m1_read, m0_read};
  assign write_vec = {m1_write, m0_write};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign req[gi]          = read_vec[gi] | write_vec[gi];
      // A simultaneous read+write is treated as a write only.
      assign rd_only[gi]      = read_vec[gi] & ~write_vec[gi];
      assign wait_vec[gi]     = req[gi] & ~grant[gi];
      assign rd_pend_next[gi] = grant[gi] & rd_only[gi];
      // Reset masks a return that was already in flight when reset rose.
      assign rdv_vec[gi]      = rd_pend_reg[gi] & ~reset;
    end
  endgenerate

  always_comb begin
    grant = 2'b00;
    if (!reset && !freeze) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_reg    <= 2'b00;
      last_grant_reg <= 1'b1;
    end else begin
      rd_pend_reg <= rd_pend_next;
      if (grant != 2'b00) begin
        last_grant_reg <= grant[1];
      end
    end
  end

  // Idle cycles still drive m0's fields so the RAM pins never float to X.
  assign sel_m1         = grant[1];
  assign mem_address    = sel_m1 ? m1_address    : m0_address;
  assign mem_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel_m1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = |grant;
  assign mem_write      = (grant[1] & m1_write) | (grant[0] & m0_write);
  assign mem_clken      = 1'b1;

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdatavalid = rdv_vec[0];
  assign m1_readdatavalid = rdv_vec[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
